apb4_mem_slave: RTL and testbench

APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

---
 rtl/apb4_mem_slave.sv | 106 ++++++++++
 tb/tb_apb4_mem_slave.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_slave.sv
// APB4 word-addressed memory slave with configurable wait states and byte strobes.
// Define APB4_MEM_SLAVE_SLVERR_EN to flag out-of-range or misaligned addresses with PSLVERR.
module apb4_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [31:0]             PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    // state  | meaning
    // IDLE   | no transfer in progress, waiting for a setup phase
    // ACCESS | access phase, counting down wait states before PREADY

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    addr_err;
    logic                    xfer_done;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign idx = PADDR[LSB +: ADDR_WIDTH];

`ifdef APB4_MEM_SLAVE_SLVERR_EN
    localparam logic [31:0] IDX_MASK = 32'((2 ** ADDR_WIDTH - 1) << LSB);
    assign addr_err = |(PADDR & ~IDX_MASK);
`else
    logic unused_paddr;
    assign unused_paddr = ^PADDR;
    assign addr_err     = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Reset held during the completion cycle aborts the transfer, so it also masks completion.
    always_comb begin
        xfer_done = PRESETn && (state_q == S_ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
        PREADY    = xfer_done;
        PSLVERR   = xfer_done && addr_err;
        wr_en     = xfer_done && PWRITE && !addr_err;
        PRDATA    = (xfer_done && !PWRITE && !addr_err) ? mem_q[idx] : '0;
    end

    always_ff @(posedge PCLK) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (PSTRB[b]) mem_q[idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: three instances with WAIT_STATES 0, 3 and 2 on a shared bus,
// checked against an array-based memory model.
module tb_apb4_mem_slave;

    logic        clk = 1'b0;
    logic        presetn;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m   [3][32];
    bit          known_m [3][32];

    always #5 clk = ~clk;

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(0)) u_ws0 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(3)) u_ws3 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(2)) u_ws2 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    // Address is legal only if it is word-aligned and inside the 32-word window.
    function automatic bit m_err(input logic [31:0] a);
`ifdef APB4_MEM_SLAVE_SLVERR_EN
        return (a & ~32'h0000_007C) != 32'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % 32);
    endfunction

    task automatic m_write(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        int w;
        w = m_idx(a);
        if (!m_err(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mem_m[k][w][b*8 +: 8] = d[b*8 +: 8];
            if (s == 4'hF) known_m[k][w] = 1'b1;
        end
    endtask

    // One APB transfer on instance k, starting at the next rising edge.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int cyc);
        bit done;
        rd   = '0;
        er   = 1'b0;
        done = 1'b0;
        @(posedge clk); #1;
        psel    = 3'b000;
        psel[k] = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = wr;
        pwdata  = d;
        pstrb   = s;
        cyc     = 1;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc++;
            @(negedge clk);
            if (pready[k]) begin
                rd   = prdata[k];
                er   = pslverr[k];
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: inst %0d addr %h got no PREADY, required PREADY within 40 cycles", k, a);
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pready[k] !== 1'b0) begin
                errors++; $display("FAIL reset_pready[%0d]: got %b required 0", k, pready[k]);
            end
            checks++;
            if (pslverr[k] !== 1'b0) begin
                errors++; $display("FAIL reset_pslverr[%0d]: got %b required 0", k, pslverr[k]);
            end
            checks++;
            if (prdata[k] !== 32'h0) begin
                errors++; $display("FAIL reset_prdata[%0d]: got %h required 0", k, prdata[k]);
            end
        end
        @(posedge clk); #1;
        presetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int cyc;
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        m_write(0, 32'h04, 32'hDEADBEEF, 4'hF);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL basic_wr_cycles: got %0d required 2", cyc); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_slverr: got %b required 0", er); end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL basic_rd_cycles: got %0d required 2", cyc); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h required deadbeef", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_slverr: got %b required 0", er); end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int cyc;
        xfer(1, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        m_write(1, 32'h08, 32'hCAFEF00D, 4'hF);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL wait_wr_cycles: got %0d required 5", cyc); end
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL wait_rd_cycles: got %0d required 5", cyc); end
        checks++;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_rd_data: got %h required cafef00d", rd); end
        bus_idle();
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er; int cyc;
        xfer(0, 1'b1, 32'h0C, 32'h11223344, 4'hF, rd, er, cyc);
        m_write(0, 32'h0C, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 32'h0C, 32'hAABBCCDD, 4'h5, rd, er, cyc);
        m_write(0, 32'h0C, 32'hAABBCCDD, 4'h5);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_rd_data: got %h required 11bb33dd", rd); end
        xfer(0, 1'b1, 32'h04, 32'h00000000, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL zero_strb_cycles: got %0d required 2", cyc); end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_strb_data: got %h required deadbeef", rd); end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int cyc; bit seen_high;
        xfer(2, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, er, cyc);
        m_write(2, 32'h10, 32'h0BADF00D, 4'hF);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL abort_prior_cycles: got %0d required 4", cyc); end
        @(posedge clk); #1;
        psel = 3'b100; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        seen_high = 1'b0;
        @(negedge clk); seen_high |= pready[2];
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk); seen_high |= pready[2];
        @(posedge clk); #1; psel = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); seen_high |= pready[2];
            @(posedge clk); #1;
        end
        penable = 1'b0;
        checks++;
        if (seen_high !== 1'b0) begin errors++; $display("FAIL abort_pready: got high required never high"); end
        xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL abort_next_cycles: got %0d required 4", cyc); end
        checks++;
        if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_rd_data: got %h required 0badf00d", rd); end
        bus_idle();
    endtask

    task automatic test_addr_err();
        logic [31:0] rd; logic er; int cyc; logic [31:0] exp_d;
        xfer(0, 1'b1, 32'h00, 32'h55AA55AA, 4'hF, rd, er, cyc);
        m_write(0, 32'h00, 32'h55AA55AA, 4'hF);
        xfer(0, 1'b1, 32'h80, 32'h00000001, 4'hF, rd, er, cyc);
        m_write(0, 32'h80, 32'h00000001, 4'hF);
        checks++;
        if (er !== m_err(32'h80)) begin errors++; $display("FAIL err_wr_slverr: got %b required %b", er, m_err(32'h80)); end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL err_wr_cycles: got %0d required 2", cyc); end
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== mem_m[0][0]) begin errors++; $display("FAIL err_word0_data: got %h required %h", rd, mem_m[0][0]); end
        xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, rd, er, cyc);
        exp_d = m_err(32'h80) ? 32'h0 : mem_m[0][0];
        checks++;
        if (er !== m_err(32'h80)) begin errors++; $display("FAIL err_rd_slverr: got %b required %b", er, m_err(32'h80)); end
        checks++;
        if (rd !== exp_d) begin errors++; $display("FAIL err_rd_data: got %h required %h", rd, exp_d); end
        xfer(0, 1'b0, 32'h05, 32'h0, 4'h0, rd, er, cyc);
        exp_d = m_err(32'h05) ? 32'h0 : mem_m[0][1];
        checks++;
        if (er !== m_err(32'h05)) begin errors++; $display("FAIL misalign_slverr: got %b required %b", er, m_err(32'h05)); end
        checks++;
        if (rd !== exp_d) begin errors++; $display("FAIL misalign_data: got %h required %h", rd, exp_d); end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int cyc;
        xfer(0, 1'b1, 32'h14, 32'h13579BDF, 4'hF, rd, er, cyc);
        m_write(0, 32'h14, 32'h13579BDF, 4'hF);
        @(posedge clk); #1;
        psel = 3'b001; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1;
        pwdata = 32'h2468ACE0; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; presetn = 1'b0;
        @(posedge clk); #1;
        presetn = 1'b1; psel = 3'b000; penable = 1'b0;
        @(negedge clk);
        checks++;
        if (pready[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pready: got %b required 0", pready[0]); end
        checks++;
        if (prdata[0] !== 32'h0) begin errors++; $display("FAIL rstmid_prdata: got %h required 0", prdata[0]); end
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL rstmid_next_cycles: got %0d required 2", cyc); end
        checks++;
        if (rd !== 32'h13579BDF) begin errors++; $display("FAIL rstmid_rd_data: got %h required 13579bdf", rd); end
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_d; logic er; int cyc, k, w, r; bit wr; logic [3:0] s;
        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 31);
            a  = 32'(w) << 2;
            r  = $urandom_range(0, 5);
            if (r == 0) a = a | ($urandom & 32'hFFFF_FF80);
            else if (r == 1) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s = 4'hF;
            xfer(k, wr, a, d, s, rd, er, cyc);
            checks++;
            if (cyc !== ws_of(k) + 2) begin
                errors++; $display("FAIL rand_cycles: inst %0d got %0d required %0d", k, cyc, ws_of(k) + 2);
            end
            checks++;
            if (er !== m_err(a)) begin
                errors++; $display("FAIL rand_slverr: inst %0d addr %h got %b required %b", k, a, er, m_err(a));
            end
            if (wr) begin
                m_write(k, a, d, s);
            end else if (m_err(a) || known_m[k][m_idx(a)]) begin
                exp_d = m_err(a) ? 32'h0 : mem_m[k][m_idx(a)];
                checks++;
                if (rd !== exp_d) begin
                    errors++; $display("FAIL rand_rd_data: inst %0d addr %h got %h required %h", k, a, rd, exp_d);
                end
            end
            if ($urandom_range(0, 4) == 0) bus_idle();
        end
        bus_idle();
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 32; w++) begin
                known_m[k][w] = 1'b0;
                mem_m[k][w]   = '0;
            end
        test_reset();
        test_basic();
        test_wait_states();
        test_strobe();
        test_abort();
        test_addr_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
